// File: rtl/lsu_pkg.sv
// Shared types and helpers for the RV64I load/store unit: access-size decode,
// alignment check, byte-lane masks, store replication and load extension.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} lsu_state_t;
  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_D = 2'b11} size_t;

  localparam logic [2:0] F3_LD_ILLEGAL = 3'b111;

  function automatic size_t get_size(input logic [2:0] f3);
    return size_t'(f3[1:0]);
  endfunction

  function automatic logic is_misaligned(input size_t sz, input logic [2:0] lane);
    logic bad;
    bad = 1'b0;
    case (sz)
      SZ_H:    bad = lane[0];
      SZ_W:    bad = |lane[1:0];
      SZ_D:    bad = |lane;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [7:0] lane_mask(input size_t sz, input logic [2:0] lane);
    logic [7:0] base;
    base = 8'h01;
    case (sz)
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      SZ_D:    base = 8'hFF;
      default: base = 8'h01;
    endcase
    return base << lane;
  endfunction

  // Replicating the low bytes onto every lane lets the byte enables pick the target lanes.
  function automatic logic [63:0] replicate(input size_t sz, input logic [63:0] d);
    logic [63:0] r;
    r = d;
    case (sz)
      SZ_B:    r = {8{d[7:0]}};
      SZ_H:    r = {4{d[15:0]}};
      SZ_W:    r = {2{d[31:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] extend(input size_t sz, input logic uns, input logic [63:0] d);
    logic [63:0] r;
    r = d;
    case (sz)
      SZ_B:    r = uns ? {56'b0, d[7:0]}  : {{56{d[7]}}, d[7:0]};
      SZ_H:    r = uns ? {48'b0, d[15:0]} : {{48{d[15]}}, d[15:0]};
      SZ_W:    r = uns ? {32'b0, d[31:0]} : {{32{d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_ram_be.sv
// DEPTH x 64-bit data RAM with per-byte write enables and a registered read,
// padded by a delay line so read data appears LATENCY cycles after the read.
module data_ram_be #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [7:0]    be_i,
  input  logic [63:0]   wdata_i,
  input  logic          re_i,
  output logic [63:0]   rdata_o
);

  logic [63:0] mem_q [DEPTH];
  logic [63:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 8; b++) begin
        if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  generate
    if (LATENCY == 1) begin : g_nopad
      assign rdata_o = rdata_q;
    end else begin : g_pad
      logic [63:0] pipe_q [LATENCY-1];
      always_ff @(posedge clk) begin
        pipe_q[0] <= rdata_q;
        for (int s = 1; s < LATENCY-1; s++) pipe_q[s] <= pipe_q[s-1];
      end
      assign rdata_o = pipe_q[LATENCY-2];
    end
  endgenerate

endmodule

// File: rtl/mem_stage_lsu.sv
// RV64I memory stage: decodes and alignment-checks requests, commits stores
// directly and sequences loads through IDLE/WAIT/RESP while stalling the pipe.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] ALUResult_M,
  input  logic [63:0] WriteData_M,
  input  logic        MemWrite_M,
  input  logic        MemRead_M,
  input  logic [2:0]  Funct3_M,
  output logic [63:0] ReadData_M,
  output logic        Stall_M,
  output logic        Misaligned_M
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  lsu_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] rdata_q;
  logic [2:0]  lane_q, f3_q;

  size_t       req_size;
  logic [2:0]  req_lane;
  logic        misaligned, ld_illegal, store_go, load_go, null_req;
  logic [63:0] ram_rdata, lane_shifted, load_ext;
  logic        unused_addr_hi;

  assign req_size       = get_size(Funct3_M);
  assign req_lane       = ALUResult_M[2:0];
  assign misaligned     = is_misaligned(req_size, req_lane);
  assign Misaligned_M   = (MemRead_M | MemWrite_M) & misaligned;
  assign ld_illegal     = MemRead_M & ~MemWrite_M & (Funct3_M == F3_LD_ILLEGAL);
  assign store_go       = (state_q == IDLE) & MemWrite_M & ~misaligned;
  assign load_go        = (state_q == IDLE) & MemRead_M & ~MemWrite_M & ~misaligned & ~ld_illegal;
  assign null_req       = (state_q == IDLE) & (Misaligned_M | ld_illegal);
  assign unused_addr_hi = ^ALUResult_M[63:AW+3];

  data_ram_be #(.DEPTH(DEPTH), .LATENCY(LATENCY)) u_ram (
    .clk     (clk),
    .addr_i  (ALUResult_M[AW+2:3]),
    .we_i    (store_go),
    .be_i    (lane_mask(req_size, req_lane)),
    .wdata_i (replicate(req_size, WriteData_M)),
    .re_i    (load_go),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    Stall_M = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_go) begin
          Stall_M = 1'b1;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        Stall_M = 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane and funct3 are captured at issue so extraction does not rely on held inputs.
  assign lane_shifted = ram_rdata >> {lane_q, 3'b000};
  assign load_ext     = extend(get_size(f3_q), f3_q[2], lane_shifted);

  always_comb begin
    if (state_q == RESP)  ReadData_M = load_ext;
    else if (null_req)    ReadData_M = '0;
    else                  ReadData_M = rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == RESP)  rdata_q <= load_ext;
      else if (null_req)    rdata_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (load_go) begin
      lane_q <= req_lane;
      f3_q   <= Funct3_M;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench: three LSUs (LATENCY 2, 1, 4) exercised one at a time with
// directed vectors; a negedge monitor pops expectations on each completed request.
module tb_mem_stage_lsu;

  localparam int NI = 3;

  typedef struct {
    int          inst;
    int          tag;
    bit          is_load;
    logic [63:0] rd;
    int          stalls;
    bit          mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] addr  [NI];
  logic [63:0] wdata [NI];
  logic [63:0] rdata [NI];
  logic [2:0]  f3    [NI];
  logic        mr    [NI];
  logic        mw    [NI];
  logic        stall [NI];
  logic        mis   [NI];

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   scnt [NI];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      mem_stage_lsu #(
        .DEPTH   (1024),
        .LATENCY (gi == 0 ? 2 : (gi == 1 ? 1 : 4))
      ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .ALUResult_M  (addr[gi]),
        .WriteData_M  (wdata[gi]),
        .MemWrite_M   (mw[gi]),
        .MemRead_M    (mr[gi]),
        .Funct3_M     (f3[gi]),
        .ReadData_M   (rdata[gi]),
        .Stall_M      (stall[gi]),
        .Misaligned_M (mis[gi])
      );
    end
  endgenerate

  task automatic chk(input string nm, input int tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (txn %0d): got 0x%016h, required 0x%016h", nm, tag, act, exp);
    end
  endtask

  // Monitor: a request seen with Stall_M low is the cycle it completes.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        scnt[i] = 0;
      end else if (mr[i] | mw[i]) begin
        if (stall[i]) begin
          scnt[i]++;
        end else begin
          if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_txn: inst %0d completed with no expectation queued", i);
          end else begin
            e = sbq.pop_front();
            chk("inst", e.tag, 64'(i), 64'(e.inst));
            chk("stall_cycles", e.tag, 64'(scnt[i]), 64'(e.stalls));
            chk("misaligned", e.tag, {63'b0, mis[i]}, {63'b0, e.mis});
            if (e.is_load || e.mis) chk("read_data", e.tag, rdata[i], e.rd);
            $display("txn %0d: inst %0d rd=0x%016h stalls=%0d mis=%0b",
                     e.tag, i, rdata[i], scnt[i], mis[i]);
          end
          scnt[i] = 0;
        end
      end
    end
  end

  task automatic txn(input int i, input int tag, input bit rd, input bit wr, input logic [2:0] fn,
                     input logic [63:0] a, input logic [63:0] d,
                     input logic [63:0] exp_rd, input int exp_stall, input bit exp_mis);
    exp_t e;
    bit   done;
    e.inst = i; e.tag = tag; e.is_load = rd & ~wr;
    e.rd = exp_rd; e.stalls = exp_stall; e.mis = exp_mis;
    @(posedge clk); #1;
    sbq.push_back(e);
    mr[i] = rd; mw[i] = wr; f3[i] = fn; addr[i] = a; wdata[i] = d;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (!stall[i]) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout (txn %0d): stall still high after 20 cycles, required release", tag);
    end
  endtask

  task automatic idle(input int i);
    @(posedge clk); #1;
    mr[i] = 1'b0;
    mw[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      addr[i] = '0; wdata[i] = '0; f3[i] = '0; mr[i] = 1'b0; mw[i] = 1'b0; scnt[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("reset_stall", 0, {63'b0, stall[i]}, 64'd0);
      chk("reset_rdata", 0, rdata[i], 64'd0);
      chk("reset_mis",   0, {63'b0, mis[i]}, 64'd0);
    end

    // LATENCY=2 instance
    txn(0,  1, 0, 1, 3'b011, 64'h40, 64'h1122334455667788, 64'h0, 0, 0);
    txn(0,  2, 1, 0, 3'b011, 64'h40, 64'h0, 64'h1122334455667788, 2, 0);
    txn(0,  3, 0, 1, 3'b000, 64'h41, 64'hAAAAAAAAAAAAAA80, 64'h0, 0, 0);
    txn(0,  4, 1, 0, 3'b000, 64'h41, 64'h0, 64'hFFFFFFFFFFFFFF80, 2, 0);
    txn(0,  5, 1, 0, 3'b100, 64'h41, 64'h0, 64'h0000000000000080, 2, 0);
    txn(0,  6, 1, 0, 3'b011, 64'h40, 64'h0, 64'h1122334455668088, 2, 0);
    txn(0,  7, 0, 1, 3'b010, 64'h44, 64'h0000000080000000, 64'h0, 0, 0);
    txn(0,  8, 1, 0, 3'b010, 64'h44, 64'h0, 64'hFFFFFFFF80000000, 2, 0);
    txn(0,  9, 1, 0, 3'b110, 64'h44, 64'h0, 64'h0000000080000000, 2, 0);
    txn(0, 10, 0, 1, 3'b001, 64'h46, 64'h0000000000008000, 64'h0, 0, 0);
    txn(0, 11, 1, 0, 3'b101, 64'h46, 64'h0, 64'h0000000000008000, 2, 0);
    txn(0, 12, 1, 0, 3'b001, 64'h46, 64'h0, 64'hFFFFFFFFFFFF8000, 2, 0);
    txn(0, 13, 0, 1, 3'b001, 64'h44, 64'h0000000000001234, 64'h0, 0, 0);
    txn(0, 14, 1, 0, 3'b101, 64'h44, 64'h0, 64'h0000000000001234, 2, 0);
    txn(0, 15, 1, 0, 3'b000, 64'h43, 64'h0, 64'h0000000000000055, 2, 0);
    txn(0, 16, 1, 0, 3'b010, 64'h42, 64'h0, 64'h0, 0, 1);
    txn(0, 17, 0, 1, 3'b011, 64'h44, 64'hDEADBEEFDEADBEEF, 64'h0, 0, 1);
    txn(0, 18, 1, 0, 3'b011, 64'h40, 64'h0, 64'h8000123455668088, 2, 0);
    txn(0, 19, 1, 0, 3'b111, 64'h40, 64'h0, 64'h0, 0, 0);
    txn(0, 20, 0, 1, 3'b011, 64'h0,  64'h0123456789ABCDEF, 64'h0, 0, 0);
    txn(0, 21, 1, 0, 3'b011, 64'h2000, 64'h0, 64'h0123456789ABCDEF, 2, 0);
    txn(0, 22, 1, 1, 3'b011, 64'h48, 64'hCAFEF00D12345678, 64'h0, 0, 0);
    txn(0, 23, 1, 0, 3'b011, 64'h48, 64'h0, 64'hCAFEF00D12345678, 2, 0);
    idle(0);
    @(negedge clk);
    chk("rdata_hold", 23, rdata[0], 64'hCAFEF00D12345678);
    addr[0] = 64'h42; f3[0] = 3'b010;
    @(negedge clk);
    chk("mis_no_req", 23, {63'b0, mis[0]}, 64'd0);

    // Abort an LD with reset while it sits in WAIT
    @(posedge clk); #1;
    mr[0] = 1'b1; f3[0] = 3'b011; addr[0] = 64'h40;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_wait_stall", 24, {63'b0, stall[0]}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0; mr[0] = 1'b0;
    @(negedge clk);
    chk("abort_stall", 24, {63'b0, stall[0]}, 64'd0);
    chk("abort_rdata", 24, rdata[0], 64'd0);
    txn(0, 25, 1, 0, 3'b011, 64'h40, 64'h0, 64'h8000123455668088, 2, 0);
    idle(0);

    // LATENCY=1 instance
    txn(1, 30, 0, 1, 3'b011, 64'h10, 64'h0F0E0D0C0B0A0908, 64'h0, 0, 0);
    txn(1, 31, 1, 0, 3'b011, 64'h10, 64'h0, 64'h0F0E0D0C0B0A0908, 1, 0);
    txn(1, 32, 1, 0, 3'b001, 64'h12, 64'h0, 64'h0000000000000B0A, 1, 0);
    txn(1, 33, 1, 0, 3'b100, 64'h17, 64'h0, 64'h000000000000000F, 1, 0);
    idle(1);

    // LATENCY=4 instance
    txn(2, 40, 0, 1, 3'b011, 64'h18, 64'hFEDCBA9876543210, 64'h0, 0, 0);
    txn(2, 41, 1, 0, 3'b011, 64'h18, 64'h0, 64'hFEDCBA9876543210, 4, 0);
    txn(2, 42, 1, 0, 3'b000, 64'h1F, 64'h0, 64'hFFFFFFFFFFFFFFFE, 4, 0);
    txn(2, 43, 1, 0, 3'b110, 64'h1C, 64'h0, 64'h00000000FEDCBA98, 4, 0);
    idle(2);

    repeat (2) @(negedge clk);
    chk("queue_drained", 99, 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
